stopwatch_display: RTL and testbench
====================================

STOPWATCH_DISPLAY -- requirements
Module: stopwatch_display

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clk cycles each digit is driven before advancing.
REQ-002 Parameter BLINK_DIV, default 25000000: clk cycles per blink half-period (used only with BLINK_EN).
REQ-003 clk  input  1  single clock; all flops on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 minutes  input  8  binary minutes from stopwatch_top.
REQ-006 seconds  input  6  binary seconds from stopwatch_top.
REQ-007 status  input  2  stopwatch state: 2'b00 IDLE, 2'b01 RUNNING, 2'b10 PAUSED.
REQ-008 seg  output  7  registered segments {g,f,e,d,c,b,a}, active-high.
REQ-009 an  output  4  registered digit enables, one-hot active-low; an[0] = seconds ones.
REQ-010 dp  output  1  registered decimal point, active-high.
REQ-011 ovf  output  1  registered; high while the displayed minutes are clamped.

Function
REQ-012 Converter FSM states: IDLE, CONV, LOAD.
REQ-013 IDLE: if {minutes,seconds} differs from the last-captured snapshot, capture both on that edge and go to CONV.
REQ-014 Capture clamps: minutes>99 -> 99 and ovf_pending=1; seconds>59 -> 59; otherwise ovf_pending=0.
REQ-015 CONV: exactly 8 shift-add-3 (double-dabble) iterations, one per cycle, on both fields in parallel; seconds zero-extended to 8 bits.
REQ-016 LOAD: write the four BCD digit registers and ovf from ovf_pending, then return to IDLE.
REQ-017 Latency: the digit registers update on the 9th rising edge after the capture edge.
REQ-018 Input changes during CONV/LOAD are not captured; the comparison is re-evaluated in IDLE, so the final stable input is always displayed.
REQ-019 Scan counter counts 0..SCAN_DIV-1; on wrap the digit index advances 0->1->2->3->0.
REQ-020 Digit index d drives an[d] low, the others high; seg = 7-segment pattern of BCD digit d; dp=1 only when d==2.
REQ-021 seg/an/dp are registered one cycle behind the digit index; an never has more than one bit low.
REQ-022 Digit patterns: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.

Reset
REQ-023 On rst: FSM=IDLE, digit registers=0, scan counter=0, digit index=0, seg=0000000, an=1111, dp=0, ovf=0, blink phase=0.
REQ-024 On rst, the snapshot register is set to 8'hFF/6'h3F so the first post-reset input is always converted.
REQ-025 rst asserted mid-conversion aborts the conversion; no partial result reaches the digit registers.

Configuration
REQ-026 Macro STOPWATCH_DISPLAY_BLINK_EN defined: a blink phase toggles every BLINK_DIV cycles; while status==PAUSED and phase==1, seg=0000000 and dp=0, with an scanning normally.
REQ-027 Macro undefined: the status input is ignored, no blink counter is built, and the display is never blanked after reset.

Structure
REQ-028 Package stopwatch_pkg holds the status encodings, the FSM state typedef, the digit-to-segment constant table and the digit count (4).
REQ-029 Sub-module bcd_dabble_seq implements the sequential 8-iteration converter (start, busy/done, two 8-bit inputs, four BCD nibbles out); the top holds capture, scan and output registers.

Verification
REQ-030 Reset, minutes=0, seconds=0: after conversion and a full scan, the digits read 00.00, dp is low on all digits except digit 2, and ovf=0.
REQ-031 minutes=12, seconds=34 held: the digit registers update 9 edges after capture; an[0] shows seg=1100110 (4) and an[3] shows seg=0000110 (1).
REQ-032 minutes=150: the display reads 99 and ovf=1; minutes is then set to 5: the display reads 05 and ovf=0.
REQ-033 seconds changes 10->11 at the 3rd CONV cycle: the display first shows 10, then 11 no more than 20 cycles later, with no intermediate garbage.
REQ-034 rst pulsed mid-CONV: outputs return to their reset values immediately; after release, the current input is converted and displayed.
REQ-035 With BLINK_EN and BLINK_DIV=8, status=2'b10: seg is blanked for 8 cycles, then shown for 8, repeating; status=2'b01: never blanked.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// ============================================================================
// stopwatch_pkg: shared encodings, converter FSM states and segment table.
// Revision: 1.0
// ============================================================================
`default_nettype none

package stopwatch_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [1:0] STATUS_IDLE    = 2'b00;
  localparam logic [1:0] STATUS_RUNNING = 2'b01;
  localparam logic [1:0] STATUS_PAUSED  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_LOAD = 2'd2
  } conv_state_t;

  // Segment order {g,f,e,d,c,b,a}, index = BCD digit value.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b1101111, 7'b1111111, 7'b0000111, 7'b1111101, 7'b1101101,
    7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
  };

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    return (d <= 4'd9) ? SEG_TABLE[d] : 7'b0000000;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_dabble_seq.sv
// ============================================================================
// bcd_dabble_seq: two parallel 8-iteration shift-add-3 binary-to-BCD converters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_dabble_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] bin_a,
  input  logic [7:0] bin_b,
  output logic       busy,
  output logic       done,
  output logic [3:0] a_tens,
  output logic [3:0] a_ones,
  output logic [3:0] b_tens,
  output logic [3:0] b_ones
);

  // {tens, ones, binary}; operands are at most 99 so two BCD nibbles suffice.
  logic [15:0] sh_a;
  logic [15:0] sh_b;
  logic [2:0]  iter;

  function automatic logic [15:0] dabble_step(input logic [15:0] s);
    logic [15:0] t;
    t = s;
    if (t[11:8] >= 4'd5)  t[11:8]  = t[11:8] + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    return {t[14:0], 1'b0};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a <= 16'd0;
      sh_b <= 16'd0;
      iter <= 3'd0;
      busy <= 1'b0;
    end else if (start) begin
      sh_a <= {8'd0, bin_a};
      sh_b <= {8'd0, bin_b};
      iter <= 3'd0;
      busy <= 1'b1;
    end else if (busy) begin
      sh_a <= dabble_step(sh_a);
      sh_b <= dabble_step(sh_b);
      iter <= iter + 3'd1;
      if (iter == 3'd7) busy <= 1'b0;
    end
  end

  // High during the cycle whose closing edge performs the final iteration.
  assign done = busy && (iter == 3'd7);

  assign a_tens = sh_a[15:12];
  assign a_ones = sh_a[11:8];
  assign b_tens = sh_b[15:12];
  assign b_ones = sh_b[11:8];

endmodule

`default_nettype wire

// File: rtl/stopwatch_display.sv
// ============================================================================
// stopwatch_display: MM.SS capture, BCD conversion and 4-digit multiplexed scan.
// Optional blanking while paused: define STOPWATCH_DISPLAY_BLINK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] minutes,
  input  logic [5:0] seconds,
  input  logic [1:0] status,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       ovf
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  conv_state_t state;
  logic [7:0]  snap_min;
  logic [5:0]  snap_sec;
  logic        ovf_pending;
  logic [3:0]  digits [NUM_DIGITS];

  logic [7:0]  clamp_min;
  logic [7:0]  clamp_sec;
  logic        clamp_ovf;
  logic        changed;
  logic        conv_start;
  logic        conv_busy;
  logic        conv_done;
  logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;

  always_comb begin
    clamp_ovf = (minutes > 8'd99);
    clamp_min = clamp_ovf ? 8'd99 : minutes;
    clamp_sec = (seconds > 6'd59) ? 8'd59 : {2'b00, seconds};
  end

  // Snapshot holds the raw inputs so a clamped value does not retrigger forever.
  assign changed    = ({minutes, seconds} != {snap_min, snap_sec});
  assign conv_start = (state == ST_IDLE) && changed;

  bcd_dabble_seq u_dabble (
    .clk    (clk),
    .rst    (rst),
    .start  (conv_start),
    .bin_a  (clamp_min),
    .bin_b  (clamp_sec),
    .busy   (conv_busy),
    .done   (conv_done),
    .a_tens (min_tens),
    .a_ones (min_ones),
    .b_tens (sec_tens),
    .b_ones (sec_ones)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      snap_min    <= 8'hFF;
      snap_sec    <= 6'h3F;
      ovf_pending <= 1'b0;
      ovf         <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (changed) begin
            snap_min    <= minutes;
            snap_sec    <= seconds;
            ovf_pending <= clamp_ovf;
            state       <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (conv_done) state <= ST_LOAD;
        end
        ST_LOAD: begin
          digits[0] <= sec_ones;
          digits[1] <= sec_tens;
          digits[2] <= min_ones;
          digits[3] <= min_tens;
          ovf       <= ovf_pending;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        digit_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt  <= scan_cnt + SCAN_W'(1);
    end
  end

  logic blank;

`ifdef STOPWATCH_DISPLAY_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + BLINK_W'(1);
    end
  end

  assign blank = (status == STATUS_PAUSED) && blink_phase;
`else
  logic unused_status;
  assign unused_status = ^status;
  assign blank = 1'b0;
`endif

  // Anodes keep scanning while blanked so brightness does not pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= 7'b0000000;
      an  <= 4'b1111;
      dp  <= 1'b0;
    end else begin
      an  <= ~(4'b0001 << digit_idx);
      seg <= blank ? 7'b0000000 : seg_of(digits[digit_idx]);
      dp  <= !blank && (digit_idx == 2'd2);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_display.sv
// ============================================================================
// tb_stopwatch_display: directed self-checking bench for stopwatch_display.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_stopwatch_display;

  localparam int SCAN_DIV  = 3;
  localparam int BLINK_DIV = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] minutes;
  logic [5:0] seconds;
  logic [1:0] status;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stopwatch_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .minutes (minutes),
    .seconds (seconds),
    .status  (status),
    .seg     (seg),
    .an      (an),
    .dp      (dp),
    .ovf     (ovf)
  );

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for digit d to be enabled and returns what it shows.
  task automatic get_digit(input int d, output logic [6:0] s, output logic p, output bit found);
    logic [3:0] want;
    want  = 4'b0001 << d;
    want  = ~want;
    found = 1'b0;
    s     = 7'bx;
    p     = 1'bx;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (an === want) begin
        found = 1'b1;
        s = seg;
        p = dp;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; minutes = 8'd0; seconds = 6'd0; status = 2'b00;
    cycles(2);
    checks++; if (seg !== 7'b0000000) begin errors++; $display("FAIL reset_seg actual=%b required=%b", seg, 7'b0000000); end
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an actual=%b required=%b", an, 4'b1111); end
    checks++; if (dp !== 1'b0) begin errors++; $display("FAIL reset_dp actual=%b required=0", dp); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf actual=%b required=0", ovf); end
  endtask

  task automatic test_zero;
    logic [6:0] s; logic p; bit f;
    rst = 1'b0;
    cycles(14);
    for (int d = 0; d < 4; d++) begin
      get_digit(d, s, p, f);
      checks++; if (!f || s !== pat(0)) begin errors++; $display("FAIL zero_seg%0d actual=%b required=%b", d, s, pat(0)); end
      checks++; if (!f || p !== (d == 2)) begin errors++; $display("FAIL zero_dp%0d actual=%b required=%b", d, p, (d == 2)); end
    end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL zero_ovf actual=%b required=0", ovf); end
  endtask

  task automatic test_latency;
    logic [6:0] s; logic p; bit f;
    minutes = 8'd12; seconds = 6'd34;
    @(posedge clk);                 // capture edge
    repeat (8) @(posedge clk);
    #1;
    checks++; if (dut.digits[0] !== 4'd0) begin errors++; $display("FAIL lat_early actual=%0d required=0", dut.digits[0]); end
    @(posedge clk);
    #1;
    checks++; if (dut.digits[0] !== 4'd4 || dut.digits[1] !== 4'd3 || dut.digits[2] !== 4'd2 || dut.digits[3] !== 4'd1) begin
      errors++; $display("FAIL lat_edge9 actual=%0d%0d%0d%0d required=1234", dut.digits[3], dut.digits[2], dut.digits[1], dut.digits[0]);
    end
    get_digit(0, s, p, f);
    checks++; if (!f || s !== pat(4)) begin errors++; $display("FAIL lat_an0 actual=%b required=%b", s, pat(4)); end
    get_digit(3, s, p, f);
    checks++; if (!f || s !== pat(1)) begin errors++; $display("FAIL lat_an3 actual=%b required=%b", s, pat(1)); end
  endtask

  task automatic test_clamp;
    logic [6:0] s; logic p; bit f;
    @(negedge clk);
    minutes = 8'd150; seconds = 6'd63;
    cycles(14);
    get_digit(3, s, p, f);
    checks++; if (!f || s !== pat(9)) begin errors++; $display("FAIL clamp_mt actual=%b required=%b", s, pat(9)); end
    get_digit(2, s, p, f);
    checks++; if (!f || s !== pat(9)) begin errors++; $display("FAIL clamp_mo actual=%b required=%b", s, pat(9)); end
    get_digit(1, s, p, f);
    checks++; if (!f || s !== pat(5)) begin errors++; $display("FAIL clamp_st actual=%b required=%b", s, pat(5)); end
    get_digit(0, s, p, f);
    checks++; if (!f || s !== pat(9)) begin errors++; $display("FAIL clamp_so actual=%b required=%b", s, pat(9)); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL clamp_ovf actual=%b required=1", ovf); end
    @(negedge clk);
    minutes = 8'd5; seconds = 6'd7;
    cycles(14);
    get_digit(3, s, p, f);
    checks++; if (!f || s !== pat(0)) begin errors++; $display("FAIL unclamp_mt actual=%b required=%b", s, pat(0)); end
    get_digit(2, s, p, f);
    checks++; if (!f || s !== pat(5)) begin errors++; $display("FAIL unclamp_mo actual=%b required=%b", s, pat(5)); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL unclamp_ovf actual=%b required=0", ovf); end
  endtask

  task automatic test_midconv_change;
    int seen10, seen11, garbage;
    logic [6:0] s; logic p; bit f;
    seen10 = -1; seen11 = -1; garbage = 0;
    @(negedge clk);
    seconds = 6'd10;                // captured on the next edge
    cycles(3);                      // now inside the third CONV cycle
    seconds = 6'd11;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (dut.digits[1] === 4'd1 && dut.digits[0] === 4'd0) begin
        if (seen10 < 0) seen10 = i;
      end else if (dut.digits[1] === 4'd1 && dut.digits[0] === 4'd1) begin
        if (seen11 < 0) seen11 = i;
      end else if (!(dut.digits[1] === 4'd0 && dut.digits[0] === 4'd7)) begin
        garbage++;
      end
    end
    checks++; if (seen10 < 0 || (seen11 >= 0 && seen11 < seen10)) begin errors++; $display("FAIL mid_first10 actual=%0d required_before=%0d", seen10, seen11); end
    checks++; if (seen11 < 0 || seen11 > 20) begin errors++; $display("FAIL mid_then11 actual=%0d required<=20", seen11); end
    checks++; if (garbage !== 0) begin errors++; $display("FAIL mid_garbage actual=%0d required=0", garbage); end
    get_digit(0, s, p, f);
    checks++; if (!f || s !== pat(1)) begin errors++; $display("FAIL mid_seg actual=%b required=%b", s, pat(1)); end
  endtask

  task automatic test_reset_midconv;
    logic [6:0] s; logic p; bit f;
    @(negedge clk);
    minutes = 8'd42; seconds = 6'd17;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (seg !== 7'b0000000 || an !== 4'b1111 || dp !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL rstmid_out actual=%b/%b/%b/%b required=0000000/1111/0/0", seg, an, dp, ovf);
    end
    checks++; if (dut.digits[0] !== 4'd0 || dut.digits[1] !== 4'd0 || dut.digits[2] !== 4'd0 || dut.digits[3] !== 4'd0) begin
      errors++; $display("FAIL rstmid_digits actual=%0d%0d%0d%0d required=0000", dut.digits[3], dut.digits[2], dut.digits[1], dut.digits[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    cycles(14);
    get_digit(3, s, p, f);
    checks++; if (!f || s !== pat(4)) begin errors++; $display("FAIL rstmid_mt actual=%b required=%b", s, pat(4)); end
    get_digit(0, s, p, f);
    checks++; if (!f || s !== pat(7)) begin errors++; $display("FAIL rstmid_so actual=%b required=%b", s, pat(7)); end
  endtask

  task automatic test_status;
    int blanks, multi, bad_period;
    bit b [48];
    status = 2'b10;
    blanks = 0; multi = 0; bad_period = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      b[i] = (seg === 7'b0000000);
      if (b[i]) blanks++;
      if ($countones(~an) != 1) multi++;
    end
    checks++; if (multi !== 0) begin errors++; $display("FAIL onehot_an actual=%0d required=0", multi); end
`ifdef STOPWATCH_DISPLAY_BLINK_EN
    for (int i = 8; i < 48; i++) if (b[i] == b[i-8]) bad_period++;
    checks++; if (bad_period !== 0) begin errors++; $display("FAIL blink_period actual=%0d required=0", bad_period); end
    checks++; if (blanks !== 24) begin errors++; $display("FAIL blink_count actual=%0d required=24", blanks); end
`else
    checks++; if (blanks !== 0) begin errors++; $display("FAIL paused_noblank actual=%0d required=0", blanks); end
`endif
    status = 2'b01;
    blanks = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (seg === 7'b0000000) blanks++;
    end
    checks++; if (blanks !== 0) begin errors++; $display("FAIL running_noblank actual=%0d required=0", blanks); end
  endtask

  initial begin
    test_reset;
    test_zero;
    test_latency;
    test_clamp;
    test_midconv_change;
    test_reset_midconv;
    test_status;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
